seq_gen: RTL and testbench

//  Serial pattern transmitter: the sending end of the single-bit serial line monitored by seq_detect.
//  On an accepted start it shifts a captured pattern out MSB-first on x, one bit per clk, then idles.
//  It drives detector stimulus in system test and the serial bit source in the datapath.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_gen_shifter.sv | 80 ++++++++
 rtl/seq_gen.sv | 155 +++++++++++++++
 tb/tb_seq_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Package seq_pkg: definitions shared by the serial pattern transmitter
// (seq_gen) and the benches of the matching detector (seq_detect).
//  - FSM state encoding for seq_gen (IDLE / SEND / GAP)
//  - len_w(): width of a length field able to hold 0..max_len
//  - default MAX_LEN / IDLE_BIT / GAP values
package seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int   DEF_MAX_LEN  = 8;
  localparam logic DEF_IDLE_BIT = 1'b1;
  localparam int   DEF_GAP      = 2;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// seq_gen_shifter: MSB-first shift register plus bit down-counter.
//  A load left-aligns the pattern so bit (len-1) sits in the MSB; each shift
//  advances one bit. The aligned pattern and length are kept so the frame
//  can be replayed by a reload without new inputs.
// Ports:
//  clk, reset      clock, asynchronous active-high reset
//  i_load          capture i_pattern / i_len and start a frame
//  i_reload        restart the frame from the captured pattern
//  i_shift         advance one bit
//  i_pattern       pattern, MAX_LEN bits
//  i_len           length in bits, already clamped to 1..MAX_LEN
//  o_bit_next      bit that will be on the line after this edge
//  o_last          current bit is the last of the frame
//  o_last_next     bit after this edge is the last of the frame
module seq_gen_shifter
  import seq_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_reload,
  input  logic               i_shift,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LW-1:0]      i_len,
  output logic               o_bit_next,
  output logic               o_last,
  output logic               o_last_next
);

  logic [MAX_LEN-1:0] r_sr;
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_cnt;
  logic [LW-1:0]      r_len;

  logic [MAX_LEN-1:0] w_aligned;
  logic [MAX_LEN-1:0] w_sr_next;
  logic [LW-1:0]      w_cnt_next;

  // Shift the unused upper bits out so the first bit to send is the MSB.
  assign w_aligned = i_pattern << (LW'(MAX_LEN) - i_len);

  always_comb begin
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    if (i_load) begin
      w_sr_next  = w_aligned;
      w_cnt_next = i_len;
    end else if (i_reload) begin
      w_sr_next  = r_pat;
      w_cnt_next = r_len;
    end else if (i_shift) begin
      w_sr_next  = r_sr << 1;
      w_cnt_next = r_cnt - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_pat <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      r_sr  <= w_sr_next;
      r_cnt <= w_cnt_next;
      if (i_load) begin
        r_pat <= w_aligned;
        r_len <= i_len;
      end
    end
  end

  assign o_bit_next  = w_sr_next[MAX_LEN-1];
  assign o_last      = (r_cnt == LW'(1));
  assign o_last_next = (w_cnt_next == LW'(1));

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. On start&&ready (len_in != 0) the
// pattern is captured and shifted out MSB-first on x, one bit per clock,
// followed by GAP forced idle cycles before ready returns.
// Optional macro SEQ_GEN_REPEAT_EN adds input repeat_en: when high at the end
// of a frame's gap (or its last bit when GAP==0) the captured pattern is sent
// again without a new start.
// Ports:
//  clk         rising-edge clock
//  reset       asynchronous active-high reset, aborts any frame
//  start       frame request, accepted only while ready=1
//  pattern_in  pattern, bit len_in-1 sent first
//  len_in      length in bits (0 ignored, >MAX_LEN clamped)
//  repeat_en   (SEQ_GEN_REPEAT_EN only) replay captured pattern
//  ready       idle and able to accept start
//  x           serial data, IDLE_BIT when not sending
//  valid       x carries a pattern bit
//  done        pulse with the last bit of a frame
module seq_gen
  import seq_pkg::*;
#(
  parameter  int   MAX_LEN  = DEF_MAX_LEN,
  parameter  logic IDLE_BIT = DEF_IDLE_BIT,
  parameter  int   GAP      = DEF_GAP,
  localparam int   LW       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LW-1:0]      len_in,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic               repeat_en,
`endif
  output logic               ready,
  output logic               x,
  output logic               valid,
  output logic               done
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;
  logic          r_x;
  logic          r_valid;
  logic          r_done;
  logic          r_ready;

  state_t        w_state_next;
  logic [GW-1:0] w_gap_next;
  logic [LW-1:0] w_len_clamp;
  logic          w_accept;
  logic          w_load;
  logic          w_reload;
  logic          w_shift;
  logic          w_rep;
  logic          w_bit_next;
  logic          w_last;
  logic          w_last_next;

`ifdef SEQ_GEN_REPEAT_EN
  assign w_rep = repeat_en;
`else
  assign w_rep = 1'b0;
`endif

  assign w_len_clamp = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;
  // r_ready is high exactly in IDLE, so it doubles as the acceptance gate.
  assign w_accept    = start && r_ready && (len_in != '0);

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    w_load       = 1'b0;
    w_reload     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last) begin
          if (GAP > 0) begin
            w_state_next = ST_GAP;
            w_gap_next   = GW'(GAP);
          end else if (w_rep) begin
            w_reload = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GW'(1)) begin
          w_gap_next = '0;
          if (w_rep) begin
            w_reload     = 1'b1;
            w_state_next = ST_SEND;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_gap_next = r_gap_cnt - GW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  seq_gen_shifter #(
    .MAX_LEN (MAX_LEN)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_reload    (w_reload),
    .i_shift     (w_shift),
    .i_pattern   (pattern_in),
    .i_len       (w_len_clamp),
    .o_bit_next  (w_bit_next),
    .o_last      (w_last),
    .o_last_next (w_last_next)
  );

  // Outputs are registered from next-state values so they line up with the
  // shift register contents after the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_x       <= IDLE_BIT;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_next;
      r_x       <= (w_state_next == ST_SEND) ? w_bit_next : IDLE_BIT;
      r_valid   <= (w_state_next == ST_SEND);
      r_done    <= (w_state_next == ST_SEND) && w_last_next;
      r_ready   <= (w_state_next == ST_IDLE);
    end
  end

  assign ready = r_ready;
  assign x     = r_x;
  assign valid = r_valid;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start0;
  logic [7:0] pattern_in, pat0;
  logic [3:0] len_in, len0;
  logic       rep;
  logic       ready, x, valid, done;
  logic       ready0, x0, valid0, done0;

  int n_cmp = 0;
  int n_err = 0;

  logic       q_bits[$];
  logic [3:0] q_vec[$];

  always #5 clk = ~clk;

  seq_gen #(.MAX_LEN(8), .IDLE_BIT(1'b1), .GAP(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern_in (pattern_in),
    .len_in     (len_in),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_en  (rep),
`endif
    .ready      (ready),
    .x          (x),
    .valid      (valid),
    .done       (done)
  );

  seq_gen #(.MAX_LEN(8), .IDLE_BIT(1'b1), .GAP(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start0),
    .pattern_in (pat0),
    .len_in     (len0),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_en  (1'b0),
`endif
    .ready      (ready0),
    .x          (x0),
    .valid      (valid0),
    .done       (done0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_rdy);
    chk({tag, "_x"}, x, 1'b1);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ready"}, ready, exp_rdy);
  endtask

  // One frame on u_dut; expected bits queued at request time, checked as sent.
  task automatic frame_a(input string tag, input logic [7:0] pat, input logic [3:0] len);
    int  L;
    int  guard;
    logic e;
    L = (len > 4'd8) ? 8 : int'(len);
    @(negedge clk);
    start = 1'b1; pattern_in = pat; len_in = len;
    for (int i = L - 1; i >= 0; i--) q_bits.push_back(pat[i]);
    @(negedge clk);
    start = 1'b0; pattern_in = ~pat; len_in = 4'd1;
    guard = 0;
    while (q_bits.size() > 0 && guard < 16) begin
      e = q_bits.pop_front();
      chk({tag, "_x"}, x, e);
      chk({tag, "_valid"}, valid, 1'b1);
      chk({tag, "_done"}, done, (q_bits.size() == 0));
      chk({tag, "_ready"}, ready, 1'b0);
      guard++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] v;
    reset = 1'b0; start = 1'b0; start0 = 1'b0; rep = 1'b0;
    pattern_in = '0; len_in = '0; pat0 = '0; len0 = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("rst", 1'b1);
    chk("rst_b_x", x0, 1'b1);
    chk("rst_b_valid", valid0, 1'b0);
    chk("rst_b_done", done0, 1'b0);
    chk("rst_b_ready", ready0, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("post_rst", 1'b1);

    // 3-bit pattern 011, then the 2-cycle gap and ready again
    frame_a("t2", 8'h03, 4'd3);
    chk_idle("t2_gap1", 1'b0);
    @(negedge clk);
    chk_idle("t2_gap2", 1'b0);
    @(negedge clk);
    chk_idle("t2_idle", 1'b1);

    // reset while the second bit (0) of A5 is on the line
    start = 1'b1; pattern_in = 8'hA5; len_in = 4'd8;
    @(negedge clk);
    start = 1'b0;
    chk("t1_b7", x, 1'b1);
    @(negedge clk);
    chk("t1_b6", x, 1'b0);
    chk("t1_b6_valid", valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t1_rst_x", x, 1'b1);
    chk("t1_rst_valid", valid, 1'b0);
    chk("t1_rst_ready", ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("t1_after", 1'b1);

    // zero length ignored, oversize length clamped to 8
    start = 1'b1; pattern_in = 8'hFF; len_in = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk_idle("t3_len0_a", 1'b1);
    @(negedge clk);
    chk_idle("t3_len0_b", 1'b1);
    frame_a("t3_len12", 8'hC9, 4'd12);
    chk_idle("t3_gap1", 1'b0);
    @(negedge clk);
    chk_idle("t3_gap2", 1'b0);
    @(negedge clk);
    chk_idle("t3_idle", 1'b1);

    // start held high: frame(2) gap gap idle frame(2) ... ; entries {valid,ready,x}
    start = 1'b1; pattern_in = 8'h02; len_in = 4'd2;
    for (int k = 0; k < 12; k++) begin
      case (k % 5)
        0: q_vec.push_back(4'b0101);
        1: q_vec.push_back(4'b0100);
        4: q_vec.push_back(4'b0011);
        default: q_vec.push_back(4'b0001);
      endcase
    end
    while (q_vec.size() > 0) begin
      @(negedge clk);
      v = q_vec.pop_front();
      chk("t4_valid", valid, v[2]);
      chk("t4_ready", ready, v[1]);
      chk("t4_x", x, v[0]);
    end
    start = 1'b0;
    @(negedge clk);
    chk_idle("t4_gap1", 1'b0);
    @(negedge clk);
    chk_idle("t4_gap2", 1'b0);
    @(negedge clk);
    chk_idle("t4_idle", 1'b1);
    @(negedge clk);
    chk_idle("t4_stay", 1'b1);

    // GAP=0 back-to-back 1-bit frames; entries {x,valid,done,ready}
    start0 = 1'b1; pat0 = 8'h00; len0 = 4'd1;
    for (int k = 0; k < 6; k++) q_vec.push_back((k % 2 == 0) ? 4'b0110 : 4'b1001);
    while (q_vec.size() > 0) begin
      @(negedge clk);
      v = q_vec.pop_front();
      chk("t5_x", x0, v[3]);
      chk("t5_valid", valid0, v[2]);
      chk("t5_done", done0, v[1]);
      chk("t5_ready", ready0, v[0]);
    end
    start0 = 1'b0;
    @(negedge clk);
    chk("t5_end_valid", valid0, 1'b0);
    chk("t5_end_ready", ready0, 1'b1);

`ifdef SEQ_GEN_REPEAT_EN
    // repeat 0110 until repeat_en drops mid-frame; entries {valid,ready,x}
    rep = 1'b1;
    start = 1'b1; pattern_in = 8'h06; len_in = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      q_vec.push_back(4'b0100); q_vec.push_back(4'b0101);
      q_vec.push_back(4'b0101); q_vec.push_back(4'b0100);
      q_vec.push_back(4'b0001); q_vec.push_back(4'b0001);
    end
    q_vec.push_back(4'b0011);
    for (int k = 0; q_vec.size() > 0; k++) begin
      v = q_vec.pop_front();
      chk("t6_valid", valid, v[2]);
      chk("t6_ready", ready, v[1]);
      chk("t6_x", x, v[0]);
      if (k == 7) rep = 1'b0;
      @(negedge clk);
    end
    chk_idle("t6_stay", 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
